// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter: grant held for a whole cyc tenure, watchdog aborts hung cycles.
// Slave side is a combinational mux on the registered grant, so the granted master sees zero added latency.
module wb_arbiter2 #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 256,
    parameter int AW            = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [3:0]    m0_sel,
    input  logic [AW-1:0] m0_adr,
    input  logic [31:0]   m0_dat_m,
    output logic [31:0]   m0_dat_s,
    output logic          m0_ack,
    output logic          m0_stall,
    output logic          m0_err,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [3:0]    m1_sel,
    input  logic [AW-1:0] m1_adr,
    input  logic [31:0]   m1_dat_m,
    output logic [31:0]   m1_dat_s,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          m1_err,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [3:0]    s_sel,
    output logic [AW-1:0] s_adr,
    output logic [31:0]   s_dat_m,
    input  logic [31:0]   s_dat_s,
    input  logic          s_ack,
    input  logic          s_stall,
    output logic [1:0]    grant_o
);

    typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;

    localparam bit          WD_EN   = (TIMEOUT > 0);
    localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_q, state_d, pick;
    logic        last_q;   // 1 when m1 held the most recent grant
    logic [1:0]  hold_q;   // per-master hold-off after a watchdog abort
    logic [31:0] wd_q;
    logic        req0, req1, own_cyc, timeout;

    assign req0 = m0_cyc & ~hold_q[0];
    assign req1 = m1_cyc & ~hold_q[1];

    assign own_cyc = (state_q == S_GNT0) ? m0_cyc :
                     (state_q == S_GNT1) ? m1_cyc : 1'b0;

    // An ack landing in the final watchdog cycle still completes the access.
    assign timeout = WD_EN && own_cyc && (wd_q == WD_LAST) && !s_ack;

    assign m0_dat_s = s_dat_s;
    assign m1_dat_s = s_dat_s;

    always_comb begin
        pick = S_IDLE;
        if (req0 && req1)
            pick = (PRIORITY_MODE == 1 && !last_q) ? S_GNT1 : S_GNT0;
        else if (req0)
            pick = S_GNT0;
        else if (req1)
            pick = S_GNT1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = pick;
            S_GNT0:  if (timeout) state_d = S_IDLE; else if (!m0_cyc) state_d = pick;
            S_GNT1:  if (timeout) state_d = S_IDLE; else if (!m1_cyc) state_d = pick;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            hold_q  <= 2'b00;
            wd_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            hold_q[0] <= (timeout && state_q == S_GNT0) | (hold_q[0] & m0_cyc);
            hold_q[1] <= (timeout && state_q == S_GNT1) | (hold_q[1] & m1_cyc);
            if (state_d != state_q) begin
                wd_q <= 32'd0;
                if (state_d == S_GNT0)
                    last_q <= 1'b0;
                else if (state_d == S_GNT1)
                    last_q <= 1'b1;
            end else if (s_ack) begin
                wd_q <= 32'd0;
            end else if (WD_EN && own_cyc) begin
                wd_q <= wd_q + 32'd1;
            end
        end
    end

    always_comb begin
        grant_o  = 2'b00;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = 4'h0;
        s_adr    = '0;
        s_dat_m  = 32'h0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_stall = 1'b1;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_stall = 1'b1;
        case (state_q)
            S_GNT0: begin
                grant_o  = 2'b01;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_adr    = m0_adr;
                s_dat_m  = m0_dat_m;
                m0_ack   = s_ack;
                m0_err   = timeout;
                m0_stall = s_stall;
            end
            S_GNT1: begin
                grant_o  = 2'b10;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_adr    = m1_adr;
                s_dat_m  = m1_dat_m;
                m1_ack   = s_ack;
                m1_err   = timeout;
                m1_stall = s_stall;
            end
            default: ;
        endcase
    end

endmodule
